// File: rtl/video_line_sched.sv
// Ping-pong line-buffer scheduler: prefetches one source line ahead of scan-out,
// repeats lines for vertical scaling and flags render underruns.
// Optional LINESCHED_UNDERRUN_CNT_EN implements the saturating underrun counter.
module video_line_sched #(
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned LINE_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic [1:0]        pixel_height,
    output logic              render_start,
    output logic [LINE_W-1:0] render_line,
    output logic              render_buf,
    input  logic              render_done,
    output logic              display_buf,
    output logic              underrun,
    input  logic              underrun_clr,
    output logic [7:0]        underrun_cnt
);
    localparam int unsigned Y_W  = 11;
    localparam int unsigned HT_W = 2;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, READY = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [HT_W-1:0]   rep_cnt, rep_cnt_nxt;
    logic [HT_W-1:0]   ht_l, ht_l_nxt;
    logic [Y_W-1:0]    y_out, y_out_nxt;
    logic              first, first_nxt;
    logic              render_start_nxt;
    logic [LINE_W-1:0] render_line_nxt;
    logic              render_buf_nxt;
    logic              display_buf_nxt;
    logic              underrun_nxt;

    logic              swap_pt;
    logic              line_ok;
    logic              ur_evt;
    logic [Y_W-1:0]    y_after;
    logic              more;

    // Swap point qualification; frame_start masks any coincident line_start
    assign swap_pt = line_start && !frame_start && (first || (rep_cnt == HT_W'(0)));
    assign line_ok = (state == READY) || ((state == BUSY) && render_done);
    assign ur_evt  = swap_pt && (state == BUSY) && !render_done;
    assign y_after = y_out + Y_W'(ht_l) + Y_W'(1);
    assign more    = y_after < Y_W'(V_ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = BUSY;
        end else if (swap_pt && line_ok) begin
            state_nxt = more ? BUSY : IDLE;
        end else if ((state == BUSY) && render_done) begin
            state_nxt = READY;
        end
    end

    always_comb begin
        render_start_nxt = 1'b0;
        render_line_nxt  = render_line;
        render_buf_nxt   = render_buf;
        display_buf_nxt  = display_buf;
        rep_cnt_nxt      = rep_cnt;
        ht_l_nxt         = ht_l;
        y_out_nxt        = y_out;
        first_nxt        = first;
        if (frame_start) begin
            ht_l_nxt         = pixel_height;
            y_out_nxt        = '0;
            rep_cnt_nxt      = '0;
            first_nxt        = 1'b1;
            render_start_nxt = 1'b1;
            render_line_nxt  = '0;
            render_buf_nxt   = ~display_buf;
        end else if (line_start) begin
            y_out_nxt = (y_out >= Y_W'(V_ACTIVE)) ? y_out : y_out + Y_W'(1);
            if (swap_pt) begin
                if (line_ok) begin
                    display_buf_nxt = render_buf;
                    rep_cnt_nxt     = ht_l;
                    first_nxt       = 1'b0;
                    if (more) begin
                        render_start_nxt = 1'b1;
                        render_line_nxt  = render_line + LINE_W'(1);
                        render_buf_nxt   = display_buf;
                    end
                end
            end else begin
                rep_cnt_nxt = rep_cnt - HT_W'(1);
            end
        end
        // A same-cycle underrun overrides the clear
        if (ur_evt) begin
            underrun_nxt = 1'b1;
        end else if (underrun_clr) begin
            underrun_nxt = 1'b0;
        end else begin
            underrun_nxt = underrun;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            render_start <= 1'b0;
            render_line  <= '0;
            render_buf   <= 1'b0;
            display_buf  <= 1'b0;
            underrun     <= 1'b0;
            rep_cnt      <= '0;
            ht_l         <= '0;
            y_out        <= '0;
            first        <= 1'b0;
        end else begin
            render_start <= render_start_nxt;
            render_line  <= render_line_nxt;
            render_buf   <= render_buf_nxt;
            display_buf  <= display_buf_nxt;
            underrun     <= underrun_nxt;
            rep_cnt      <= rep_cnt_nxt;
            ht_l         <= ht_l_nxt;
            y_out        <= y_out_nxt;
            first        <= first_nxt;
        end
    end

`ifdef LINESCHED_UNDERRUN_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else if (ur_evt) begin
            if (underrun_clr) begin
                cnt_q <= 8'd1;
            end else if (cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end else if (underrun_clr) begin
            cnt_q <= 8'd0;
        end
    end

    assign underrun_cnt = cnt_q;
`else
    assign underrun_cnt = 8'd0;
`endif

endmodule

// File: doc/video_line_sched.md
Name: video_line_sched

Overview:
- Schedules rendering of source lines into a two-bank (ping-pong) line buffer, one line ahead of the VGA scan-out.
- Applies vertical scaling by repeating each source line pixel_height+1 times.
- Selects the bank the VGA output reads from, and detects and counts render underruns.
- Sits between the video timing generator, the line renderer and the line-buffer bank selects.

Parameters:
- V_ACTIVE, 480, number of active output lines per frame.
- LINE_W, 9, width of the source line index.

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- frame_start  in  1  one-cycle pulse in vertical blank, before the first active line_start
- line_start  in  1  one-cycle pulse at the start of each active output line only
- pixel_height  in  2  vertical scale; each source line is shown pixel_height+1 times
- render_start  out  1  one-cycle pulse requesting a line render
- render_line  out  LINE_W  source line to render; valid with render_start, held until the next render_start
- render_buf  out  1  bank the renderer writes
- render_done  in  1  one-cycle pulse from the renderer, render complete
- display_buf  out  1  bank scan-out reads
- underrun  out  1  sticky flag: a line was not ready at its swap point
- underrun_clr  in  1  clears underrun and underrun_cnt
- underrun_cnt  out  8  saturating underrun count

Behaviour:
- Reset values: state IDLE; render_start=0, render_line=0, render_buf=0, display_buf=0, underrun=0, underrun_cnt=0. Internal rep_cnt=0, y_out=0, ht_l=0.
- States:
  - IDLE: no render outstanding, nothing prefetched.
  - BUSY: render outstanding.
  - READY: render done, awaiting swap.
- frame_start (highest priority, any state):
  - Latch ht_l<=pixel_height; ht_l is constant for the rest of the frame.
  - Set y_out<=0, rep_cnt<=0, first<=1.
  - Pulse render_start the next cycle with render_line=0 and render_buf=~display_buf; enter BUSY.
  - A render_done in the same cycle is ignored. A previous render still in progress is abandoned; a late render_done from it must not arrive. This is a renderer contract, and the renderer restarts on render_start.
- render_done in BUSY: go to READY the next cycle. render_done in IDLE or READY is ignored.
- line_start, swap case (first=1 or rep_cnt==0):
  - If READY, or BUSY with render_done in the same cycle:
    - display_buf<=render_buf; rep_cnt<=ht_l; first<=0.
    - Compute nxt=y_out+ht_l+1, using 11-bit arithmetic.
    - If nxt<V_ACTIVE: pulse render_start the next cycle with render_line+1 into the other bank (new render_buf = old display_buf); enter BUSY.
    - Else enter IDLE; no more prefetch this frame.
  - If BUSY without render_done: underrun:
    - display_buf is unchanged and the previous line repeats.
    - underrun<=1; underrun_cnt increments, saturating at 255.
    - rep_cnt stays 0, so the swap is retried at the next line_start.
  - If IDLE: no swap, no underrun; display_buf holds.
- line_start, repeat case (rep_cnt!=0): rep_cnt<=rep_cnt-1; display_buf is unchanged; a prefetch in progress continues.
- Every line_start: y_out<=y_out+1, saturating at V_ACTIVE.
- render_start latency: 1 cycle after the triggering frame_start or line_start. render_start never fires while BUSY.
- render_line wraps modulo 2^LINE_W.
- underrun_clr: clears underrun and underrun_cnt. An underrun in the same cycle wins: underrun=1, underrun_cnt=1.
- frame_start and line_start in the same cycle: frame_start wins, line_start is ignored.
- Reset mid-frame: all state returns to reset values. Nothing is rendered until the next frame_start.

Optional Feature:
- Macro LINESCHED_UNDERRUN_CNT_EN.
- Defined: the 8-bit saturating underrun_cnt register is implemented as described above.
- Undefined: no counter register; underrun_cnt is tied to 8'd0. The sticky underrun flag and underrun_clr behave identically.

Test Plan:
- Scale 1x, instant renderer: pixel_height=0, frame_start, render_done 5 cycles after each render_start, 480 line_starts.
  - render_line sequence 0..479; display_buf toggles every line; exactly 480 render_starts; IDLE after the last; underrun=0.
- Scale 2x: pixel_height=1.
  - render_line 0..239; display_buf toggles every 2nd line_start; 240 render_starts; the last render_start follows line_start #477 (y_out=476).
- Underrun: pixel_height=0; withhold render_done for line 3 across one line_start.
  - display_buf holds for one extra line; underrun=1, underrun_cnt=1.
  - After render_done, the next line_start swaps and render_line=4 is issued.
- Same-cycle events:
  - render_done coincident with line_start: swap with no underrun.
  - frame_start coincident with line_start: render_line=0, y_out=0.
  - underrun_clr coincident with an underrun: underrun_cnt=1.
- Saturation and clear: 300 forced underruns give underrun_cnt=255; underrun_clr gives 0 and underrun=0. With the macro undefined, underrun_cnt is 0 throughout.
- Mid-frame events: pixel_height changed mid-frame from 0 to 3 takes effect only after the next frame_start; rst asserted mid-render returns all outputs to reset values and issues no render_start until frame_start.
